decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised RISC-V instruction decode stage between fetch and execute.
- Splits each fetched instruction into register, function and shift fields, and builds a fully sign-extended immediate for every format (I/S/B/U/J). J-type immediates are sign-extended.
- Flags illegal encodings and carries the PC through.
- Adds valid/ready handshaking, an optional skid buffer and a synchronous flush, so the pipeline can stall and redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets imm width and shamt width.
SKID, 1, 1 = two-entry output (main and skid register) with registered in_ready; 0 = single register with combinational in_ready.
EXT_M, 0, 1 = accept funct7=0000001 on R-type (RV M extension).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
flush  in  1  discard all held and incoming instructions this cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept an instruction
in_pc  in  XLEN  PC of the instruction
in_inst  in  32  instruction word
out_valid  out  1  decoded instruction is available
out_ready  in  1  execute consumes the decoded instruction
out_pc  out  XLEN  PC of the decoded instruction
opcode  out  7  inst[6:0]
rd  out  5  destination register; 0 if the format has none
rs1  out  5  source register 1; 0 if unused
rs2  out  5  source register 2; 0 if unused
funct3  out  3  0 for U/J
funct7  out  7  R-type funct7; 0100000 for SRAI; else 0
imm  out  XLEN  sign-extended immediate; 0 for R-type and shift-immediates
shamt  out  $clog2(XLEN)  shift amount for SLLI/SRLI/SRAI; else 0
illegal  out  1  unsupported or illegal encoding

Behaviour:
Reset:
- reset_n=0 at a clock edge clears all outputs to 0 and empties both registers.
- in_ready=1 after reset.
- Inputs are ignored while reset_n=0.
- Reset mid-stall drops any held instructions.

Latency and handshake:
- Latency is exactly 1 cycle: an instruction accepted at edge N is presented at edge N+1.
- Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- Outputs stay stable while out_valid && !out_ready.
- Order is strictly FIFO.

SKID=0:
- in_ready = !out_valid || out_ready (combinational).

SKID=1:
- in_ready = !skid_valid (registered).
- An accept while main is full and not draining goes to the skid register.
- When main drains, skid moves to main the same edge.
- A simultaneous drain and accept with skid empty loads main directly.

Flush:
- flush=1 clears out_valid and skid_valid at the edge.
- An input presented in the same cycle is dropped, regardless of in_valid or in_ready.
- Priority order: reset > flush > handshake.

Decode (combinational on in_inst, registered on accept):
- R (0110011):
  - rd, rs1, rs2, funct3, funct7 taken from the instruction.
  - Illegal if funct7 is not 0000000 or 0100000, unless EXT_M and funct7=0000001.
  - 0100000 is legal only with funct3 000 or 101.
- I-ALU (0010011):
  - funct3 001/101 are shifts: shamt = inst[20+:$clog2(XLEN)], imm=0.
  - SRAI when inst[30]=1: funct7=0100000.
  - If XLEN=32 and inst[25]=1: illegal.
  - All other funct3: imm = sext(inst[31:20]).
- LOAD (0000011): imm = sext(inst[31:20]).
  - Illegal funct3: 011, 110, 111 (XLEN=32); 111 (XLEN=64).
- JALR (1100111): imm = sext(inst[31:20]); funct3≠000 is illegal.
- SYSTEM (1110011): imm = sext(inst[31:20]).
- S (0100011): imm = sext({inst[31:25], inst[11:7]}).
  - funct3 > 010 is illegal (>011 when XLEN=64).
- B (1100011): imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); funct3 010/011 are illegal.
- LUI/AUIPC (0110111/0010111): imm = sext({inst[31:12], 12'b0}).
- JAL (1101111): imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Illegal encodings:
  - Triggered by an unlisted opcode or inst[1:0]≠11.
  - illegal=1; opcode and out_pc are passed through; all other fields are 0.
  - out_valid is still asserted so that execute traps.

Test Plan:
- Reset then in_inst=0xFFF10093 (addi x1,x2,-1), in_pc=0x100, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, out_pc=0x100, illegal=0.
- 0xFFDFF0EF (jal x1,-4) -> imm=0xFFFFFFFC, rd=1, rs1=rs2=0. Then 0x40335293 (srai x5,x6,3) -> shamt=3, funct7=0x20, imm=0.
- SKID=1, out_ready=0, three back-to-back valid inputs A, B, C -> A and B accepted and in_ready=0 after B; C is held. Raise out_ready -> A, B, C are output in consecutive cycles with no loss or duplication.
- in_inst=0x00000000, then 0x0000200F-style unknown opcode -> illegal=1, out_valid=1, all fields 0 except opcode. R-type with funct7=0000001 -> illegal=1 when EXT_M=0, 0 when EXT_M=1.
- Stalled with main and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and concurrent instructions never appear.
- reset_n=0 for one cycle during a stall -> all outputs 0, out_valid=0; the next accepted instruction decodes normally with 1-cycle latency.

Source files
------------

// File: rtl/decode_stage.sv
// RISC-V decode stage: splits the fetched word into fields and a sign-extended
// immediate, with valid/ready flow control, an optional skid entry and a flush.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int EXT_M = 0
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [XLEN-1:0]         i_in_pc,
  input  logic [31:0]             i_in_inst,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [XLEN-1:0]         o_out_pc,
  output logic [6:0]              o_opcode,
  output logic [4:0]              o_rd,
  output logic [4:0]              o_rs1,
  output logic [4:0]              o_rs2,
  output logic [2:0]              o_funct3,
  output logic [6:0]              o_funct7,
  output logic [XLEN-1:0]         o_imm,
  output logic [$clog2(XLEN)-1:0] o_shamt,
  output logic                    o_illegal
);

  localparam int SW = $clog2(XLEN);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [SW-1:0]   shamt;
    logic            illegal;
  } dec_t;

  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic            w_r_ok;
  dec_t            w_dec;

  assign w_f3    = i_in_inst[14:12];
  assign w_f7    = i_in_inst[31:25];
  assign w_imm_i = XLEN'($signed(i_in_inst[31:20]));
  assign w_imm_s = XLEN'($signed({i_in_inst[31:25], i_in_inst[11:7]}));
  assign w_imm_b = XLEN'($signed({i_in_inst[31], i_in_inst[7], i_in_inst[30:25],
                                  i_in_inst[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_in_inst[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({i_in_inst[31], i_in_inst[19:12], i_in_inst[20],
                                  i_in_inst[30:21], 1'b0}));
  assign w_r_ok  = (w_f7 == 7'b0000000) ||
                   (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                   (EXT_M != 0 && w_f7 == 7'b0000001);

  always_comb begin
    w_dec        = '0;
    w_dec.pc     = i_in_pc;
    w_dec.opcode = i_in_inst[6:0];
    if (i_in_inst[1:0] != 2'b11) begin
      w_dec.illegal = 1'b1;
    end else begin
      case (i_in_inst[6:0])
        OP_R: begin
          w_dec.rd      = i_in_inst[11:7];
          w_dec.rs1     = i_in_inst[19:15];
          w_dec.rs2     = i_in_inst[24:20];
          w_dec.funct3  = w_f3;
          w_dec.funct7  = w_f7;
          w_dec.illegal = !w_r_ok;
        end
        OP_I_ALU: begin
          w_dec.rd     = i_in_inst[11:7];
          w_dec.rs1    = i_in_inst[19:15];
          w_dec.funct3 = w_f3;
          // Shift-immediates carry shamt instead of an immediate
          if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
            w_dec.shamt   = i_in_inst[20 +: SW];
            w_dec.illegal = (XLEN == 32) && i_in_inst[25];
            if (w_f3 == 3'b101 && i_in_inst[30]) w_dec.funct7 = 7'b0100000;
          end else begin
            w_dec.imm = w_imm_i;
          end
        end
        OP_LOAD: begin
          w_dec.rd      = i_in_inst[11:7];
          w_dec.rs1     = i_in_inst[19:15];
          w_dec.funct3  = w_f3;
          w_dec.imm     = w_imm_i;
          w_dec.illegal = (w_f3 == 3'b111) ||
                          ((XLEN == 32) && (w_f3 == 3'b011 || w_f3 == 3'b110));
        end
        OP_JALR: begin
          w_dec.rd      = i_in_inst[11:7];
          w_dec.rs1     = i_in_inst[19:15];
          w_dec.funct3  = w_f3;
          w_dec.imm     = w_imm_i;
          w_dec.illegal = (w_f3 != 3'b000);
        end
        OP_SYSTEM: begin
          w_dec.rd     = i_in_inst[11:7];
          w_dec.rs1    = i_in_inst[19:15];
          w_dec.funct3 = w_f3;
          w_dec.imm    = w_imm_i;
        end
        OP_STORE: begin
          w_dec.rs1     = i_in_inst[19:15];
          w_dec.rs2     = i_in_inst[24:20];
          w_dec.funct3  = w_f3;
          w_dec.imm     = w_imm_s;
          w_dec.illegal = w_f3 > ((XLEN == 64) ? 3'd3 : 3'd2);
        end
        OP_BRANCH: begin
          w_dec.rs1     = i_in_inst[19:15];
          w_dec.rs2     = i_in_inst[24:20];
          w_dec.funct3  = w_f3;
          w_dec.imm     = w_imm_b;
          w_dec.illegal = (w_f3 == 3'b010 || w_f3 == 3'b011);
        end
        OP_LUI, OP_AUIPC: begin
          w_dec.rd  = i_in_inst[11:7];
          w_dec.imm = w_imm_u;
        end
        OP_JAL: begin
          w_dec.rd  = i_in_inst[11:7];
          w_dec.imm = w_imm_j;
        end
        default: w_dec.illegal = 1'b1;
      endcase
    end
  end

  // Handshake: a word is accepted when in_valid && in_ready and leaves when
  // out_valid && out_ready; a presented word holds steady until it leaves.
  dec_t r_main, r_skid;
  logic r_main_v, r_skid_v;
  logic w_drain, w_accept;

  assign w_drain    = r_main_v && i_out_ready;
  assign o_in_ready = (SKID != 0) ? !r_skid_v : (!r_main_v || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (i_flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v || w_drain) begin
      if (SKID != 0 && r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_accept) begin
        r_main   <= w_dec;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (SKID != 0 && w_accept) begin
      r_skid   <= w_dec;
      r_skid_v <= 1'b1;
    end
  end

  assign o_out_valid = r_main_v;
  assign o_out_pc    = r_main.pc;
  assign o_opcode    = r_main.opcode;
  assign o_rd        = r_main.rd;
  assign o_rs1       = r_main.rs1;
  assign o_rs2       = r_main.rs2;
  assign o_funct3    = r_main.funct3;
  assign o_funct7    = r_main.funct7;
  assign o_imm       = r_main.imm;
  assign o_shamt     = r_main.shamt;
  assign o_illegal   = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, skid ordering, flush and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;

  logic        m_in_ready, m_out_valid, m_illegal;
  logic [31:0] m_out_pc, m_imm;
  logic [6:0]  m_opcode, m_funct7;
  logic [4:0]  m_rd, m_rs1, m_rs2, m_shamt;
  logic [2:0]  m_funct3;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1), .EXT_M(0)) u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_pc(in_pc), .i_in_inst(in_inst),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_pc(out_pc),
    .o_opcode(opcode), .o_rd(rd), .o_rs1(rs1), .o_rs2(rs2), .o_funct3(funct3),
    .o_funct7(funct7), .o_imm(imm), .o_shamt(shamt), .o_illegal(illegal)
  );

  decode_stage #(.XLEN(32), .SKID(0), .EXT_M(1)) u_dut_m (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(m_in_ready), .i_in_pc(in_pc), .i_in_inst(in_inst),
    .o_out_valid(m_out_valid), .i_out_ready(out_ready), .o_out_pc(m_out_pc),
    .o_opcode(m_opcode), .o_rd(m_rd), .o_rs1(m_rs1), .o_rs2(m_rs2), .o_funct3(m_funct3),
    .o_funct7(m_funct7), .o_imm(m_imm), .o_shamt(m_shamt), .o_illegal(m_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] inst, input bit keep);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    if (keep) exp_q.push_back(pc);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // scoreboard: every transfer must match the oldest expected PC
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra observed=%0h expected=none", out_pc);
      end
      if (exp_q.size() != 0) chk("sb_order", out_pc, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_imm", imm, 0);
    chk("rst_opcode", 32'(opcode), 0);

    // back-to-back decode stream
    rst_n = 1'b1; out_ready = 1'b1;
    send(32'h100, 32'hFFF10093, 1'b1); step();
    send(32'h104, 32'hFFDFF0EF, 1'b1);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_rd", 32'(rd), 1);
    chk("addi_rs1", 32'(rs1), 2);
    chk("addi_rs2", 32'(rs2), 0);
    chk("addi_f3", 32'(funct3), 0);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_ill", 32'(illegal), 0);
    step(); send(32'h108, 32'h40335293, 1'b1);
    chk("jal_imm", imm, 32'hFFFFFFFC);
    chk("jal_rd", 32'(rd), 1);
    chk("jal_rs1", 32'(rs1), 0);
    chk("jal_rs2", 32'(rs2), 0);
    chk("jal_f3", 32'(funct3), 0);
    chk("jal_opcode", 32'(opcode), 32'h6F);
    step(); send(32'h10C, 32'hFE512E23, 1'b1);
    chk("srai_shamt", 32'(shamt), 3);
    chk("srai_f7", 32'(funct7), 32'h20);
    chk("srai_imm", imm, 0);
    chk("srai_rd", 32'(rd), 5);
    chk("srai_rs1", 32'(rs1), 6);
    chk("srai_f3", 32'(funct3), 5);
    step(); send(32'h110, 32'hFE208CE3, 1'b1);
    chk("sw_imm", imm, 32'hFFFFFFFC);
    chk("sw_rs1", 32'(rs1), 2);
    chk("sw_rs2", 32'(rs2), 5);
    chk("sw_rd", 32'(rd), 0);
    chk("sw_f3", 32'(funct3), 2);
    step(); send(32'h114, 32'h123451B7, 1'b1);
    chk("beq_imm", imm, 32'hFFFFFFF8);
    chk("beq_rs1", 32'(rs1), 1);
    chk("beq_rs2", 32'(rs2), 2);
    chk("beq_rd", 32'(rd), 0);
    step(); send(32'h118, 32'h00013083, 1'b1);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rd", 32'(rd), 3);
    chk("lui_rs1", 32'(rs1), 0);
    chk("lui_f3", 32'(funct3), 0);
    chk("lui_ill", 32'(illegal), 0);
    step(); send(32'h11C, 32'h00000000, 1'b1);
    chk("ld32_ill", 32'(illegal), 1);
    step(); send(32'h120, 32'h0000200F, 1'b1);
    chk("zero_ill", 32'(illegal), 1);
    chk("zero_valid", 32'(out_valid), 1);
    chk("zero_opcode", 32'(opcode), 0);
    chk("zero_imm", imm, 0);
    chk("zero_pc", out_pc, 32'h11C);
    step(); send(32'h124, 32'h022081B3, 1'b1);
    chk("misc_ill", 32'(illegal), 1);
    chk("misc_opcode", 32'(opcode), 32'h0F);
    chk("misc_f3", 32'(funct3), 0);
    chk("misc_rd", 32'(rd), 0);
    chk("misc_imm", imm, 0);
    step(); send(32'h128, 32'h40208133, 1'b1);
    chk("mul_ill_base", 32'(illegal), 1);
    chk("mul_ill_extm", 32'(m_illegal), 0);
    chk("mul_valid_extm", 32'(m_out_valid), 1);
    chk("mul_rd_extm", 32'(m_rd), 3);
    step(); send(32'h12C, 32'h40209133, 1'b1);
    chk("sub_ill", 32'(illegal), 0);
    chk("sub_f7", 32'(funct7), 32'h20);
    chk("sub_rd", 32'(rd), 2);
    chk("sub_rs2", 32'(rs2), 2);
    step(); send(32'h130, 32'h02009093, 1'b1);
    chk("sub_f3_ill", 32'(illegal), 1);
    step(); idle();
    chk("slli_b25_ill", 32'(illegal), 1);
    step();
    chk("drained_valid", 32'(out_valid), 0);

    // skid: A, B accepted under stall, C held off
    out_ready = 1'b0;
    send(32'h200, 32'hFFF10093, 1'b1); step();
    send(32'h204, 32'h40335293, 1'b1);
    chk("skA_valid", 32'(out_valid), 1);
    chk("skA_ready", 32'(in_ready), 1);
    chk("skA_pc", out_pc, 32'h200);
    chk("nsk_ready_stall", 32'(m_in_ready), 0);
    step(); send(32'h208, 32'hFFDFF0EF, 1'b1);
    chk("skB_ready", 32'(in_ready), 0);
    chk("skB_pc", out_pc, 32'h200);
    step();
    chk("skC_ready", 32'(in_ready), 0);
    chk("skC_pc_stable", out_pc, 32'h200);
    chk("skC_imm_stable", imm, 32'hFFFFFFFF);
    out_ready = 1'b1; #1;
    chk("nsk_ready_comb", 32'(m_in_ready), 1);
    step();
    chk("skB_out_pc", out_pc, 32'h204);
    chk("skB_out_ready", 32'(in_ready), 1);
    step(); idle();
    chk("skC_out_pc", out_pc, 32'h208);
    chk("skC_out_imm", imm, 32'hFFFFFFFC);
    step();
    chk("sk_empty", 32'(out_valid), 0);

    // flush with main and skid full plus a concurrent input
    out_ready = 1'b0;
    send(32'h300, 32'hFFF10093, 1'b0); step();
    send(32'h304, 32'hFFF10093, 1'b0); step();
    chk("fl_full_ready", 32'(in_ready), 0);
    flush = 1'b1; send(32'h308, 32'hFFF10093, 1'b0); step();
    flush = 1'b0; idle();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ready", 32'(in_ready), 1);
    out_ready = 1'b1; step();
    chk("fl_still_empty", 32'(out_valid), 0);

    // reset during a full stall
    out_ready = 1'b0;
    send(32'h400, 32'hFFF10093, 1'b0); step();
    send(32'h404, 32'h40335293, 1'b0); step();
    rst_n = 1'b0; send(32'h408, 32'hFFF10093, 1'b0); step();
    rst_n = 1'b1; idle();
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_ready", 32'(in_ready), 1);
    chk("mr_pc", out_pc, 0);
    chk("mr_imm", imm, 0);
    chk("mr_rd", 32'(rd), 0);
    chk("mr_opcode", 32'(opcode), 0);
    out_ready = 1'b1;
    send(32'h40C, 32'hFFF10093, 1'b1); step(); idle();
    chk("mr_next_valid", 32'(out_valid), 1);
    chk("mr_next_pc", out_pc, 32'h40C);
    chk("mr_next_imm", imm, 32'hFFFFFFFF);
    chk("mr_next_rd", 32'(rd), 1);
    step();
    chk("mr_next_gone", 32'(out_valid), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
